// File: rtl/bmp_frame_sequencer_if.sv
// rtl/bmp_frame_sequencer_if.sv - upstream 24-bit pixel valid/ready handshake
interface bmp_frame_sequencer_if;
  logic        i_pix_valid;
  logic [23:0] i_pix_data;
  logic        o_pix_ready;

  modport master (output i_pix_valid, output i_pix_data, input o_pix_ready);
  modport slave  (input i_pix_valid, input i_pix_data, output o_pix_ready);
endinterface

// File: rtl/bmp_frame_sequencer.sv
// rtl/bmp_frame_sequencer.sv - vsync/hsync/de raster and BMP header constants for the file write model
module bmp_frame_sequencer #(
  parameter int unsigned HRES = 320,
  parameter int unsigned VRES = 240,
  parameter int unsigned HSW  = 4,
  parameter int unsigned HBP  = 8,
  parameter int unsigned HFP  = 8,
  parameter int unsigned VSW  = 2,
  parameter int unsigned VBP  = 4,
  parameter int unsigned VFP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [7:0]            i_frames,
  input  logic                  i_stop,
  bmp_frame_sequencer_if.slave  pix,
  output logic                  o_vsync,
  output logic                  o_hsync,
  output logic                  o_de,
  output logic [23:0]           o_data,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [7:0]            o_frame_cnt,
  output logic                  o_underflow,
  output logic [31:0]           o_bf_size,
  output logic [31:0]           o_bf_off_bits,
  output logic [31:0]           o_bi_width,
  output logic [31:0]           o_bi_height,
  output logic [31:0]           o_bi_size_image
);

  localparam int unsigned HTOTAL = HSW + HBP + HRES + HFP;
  localparam int unsigned VTOTAL = VSW + VBP + VRES + VFP;
  localparam int unsigned H_ACT0 = HSW + HBP;
  localparam int unsigned H_ACT1 = HSW + HBP + HRES;
  localparam int unsigned V_ACT0 = VSW + VBP;
  localparam int unsigned V_ACT1 = VSW + VBP + VRES;
  localparam int unsigned IMAGE_BYTES = HRES * VRES * 3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t      r_state;
  logic [31:0] r_h_cnt;
  logic [31:0] r_v_cnt;
  logic [7:0]  r_target;
  logic        r_stop_pending;

  logic       w_active;
  logic       w_h_last;
  logic       w_eof;
  logic       w_flush_last;
  logic [7:0] w_frame_cnt_nxt;
  logic       w_last_frame;

  assign w_active = (r_v_cnt >= V_ACT0) && (r_v_cnt < V_ACT1) &&
                    (r_h_cnt >= H_ACT0) && (r_h_cnt < H_ACT1);
  assign w_h_last        = (r_h_cnt == HTOTAL - 1);
  assign w_eof           = w_h_last && (r_v_cnt == VTOTAL - 1);
  assign w_flush_last    = w_h_last && (r_v_cnt == VSW - 1);
  assign w_frame_cnt_nxt = o_frame_cnt + 8'd1;
  // A stop arriving on the very last clock of a frame still ends that frame.
  assign w_last_frame    = ((r_target != 8'd0) && (w_frame_cnt_nxt == r_target)) ||
                           r_stop_pending || i_stop;

  assign pix.o_pix_ready = (r_state == ST_RUN) && w_active;
  assign o_busy          = (r_state != ST_IDLE);

  assign o_bf_size       = 32'd54 + IMAGE_BYTES;
  assign o_bf_off_bits   = 32'd54;
  assign o_bi_width      = HRES;
  assign o_bi_height     = VRES;
  assign o_bi_size_image = IMAGE_BYTES;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_h_cnt        <= '0;
      r_v_cnt        <= '0;
      r_target       <= '0;
      r_stop_pending <= 1'b0;
      o_vsync        <= 1'b0;
      o_hsync        <= 1'b0;
      o_de           <= 1'b0;
      o_data         <= '0;
      o_frame_done   <= 1'b0;
      o_frame_cnt    <= '0;
      o_underflow    <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          o_vsync <= 1'b0;
          o_hsync <= 1'b0;
          o_de    <= 1'b0;
          o_data  <= '0;
          r_h_cnt <= '0;
          r_v_cnt <= '0;
          if (i_start) begin
            r_state        <= ST_RUN;
            r_target       <= i_frames;
            r_stop_pending <= 1'b0;
            o_frame_cnt    <= '0;
            o_underflow    <= 1'b0;
          end
        end
        ST_RUN: begin
          o_vsync <= (r_v_cnt < VSW);
          o_hsync <= (r_h_cnt < HSW);
          o_de    <= w_active;
          o_data  <= (w_active && pix.i_pix_valid) ? pix.i_pix_data : 24'h0;
          if (w_active && !pix.i_pix_valid) o_underflow <= 1'b1;
          if (i_stop) r_stop_pending <= 1'b1;
          if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= r_v_cnt + 32'd1;
          end else begin
            r_h_cnt <= r_h_cnt + 32'd1;
          end
          if (w_eof) begin
            o_frame_done <= 1'b1;
            o_frame_cnt  <= w_frame_cnt_nxt;
            r_v_cnt      <= '0;
            if (w_last_frame) begin
              r_state        <= ST_FLUSH;
              r_stop_pending <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          // Trailing vsync line period: its edge makes the model commit the last frame.
          o_vsync <= 1'b1;
          o_hsync <= (r_h_cnt < HSW);
          o_de    <= 1'b0;
          o_data  <= '0;
          if (w_flush_last) begin
            r_state <= ST_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
          end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= r_v_cnt + 32'd1;
          end else begin
            r_h_cnt <= r_h_cnt + 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
